btn_debounce: RTL
=================

// Module: btn_debounce
// PURPOSE
//  Conditions a raw active-low push-button pad into clean, single-cycle events
//  for the timer core. It synchronises the pad, rejects bounce, and emits
//  press, release and long-press pulses. It also provides a debounced level.
//  Sits between btn_n_pad_i and the egg_timer start input, in the PLL clock domain.
// PARAMETERS
//  SYNC_STAGES      2      synchroniser flops on btn_n (>=2)
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles needed to accept a change (>=1)
//  LONG_CYCLES      25000000  held cycles, counted from press acceptance, before long pulse (>=1)
//  CNT_WIDTH        25     counter width; 2**CNT_WIDTH > max(DEBOUNCE_CYCLES,LONG_CYCLES)
// PORTS
//  clk      in   1  core clock (PLL c0)
//  rst      in   1  asynchronous, active-high reset
//  btn_n    in   1  raw pad, active-low, asynchronous to clk
//  pressed  out  1  debounced level, 1 = button held
//  press    out  1  one-cycle pulse on accepted press
//  release  out  1  one-cycle pulse on accepted release
//  long     out  1  one-cycle pulse, at most once per press, after LONG_CYCLES held
// BEHAVIOUR
//  Reset: one clock, async active-high rst. Sync chain loads 1 (released).
//   pressed=press=release=long=0. state=IDLE, both counters=0.
//  Sync: s = ~btn_n after SYNC_STAGES flops. Only s is used downstream.
//  FSM (deb_cnt counts agreeing cycles of s against the pending level):
//   IDLE:  s=1 -> PRESSING with deb_cnt=1; s=0 -> stay.
//   PRESSING: if s=0 -> IDLE, deb_cnt=0 (bounce).
//     if s=1 and deb_cnt==DEBOUNCE_CYCLES-1 -> HELD. Same edge: pressed<=1,
//       press<=1, hold_cnt<=0.
//     otherwise deb_cnt++.
//   HELD:  s=0 -> RELEASING with deb_cnt=1; s=1 -> stay.
//   RELEASING: if s=1 -> HELD, deb_cnt=0; hold_cnt is NOT cleared.
//     if s=0 and deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE. Same edge: pressed<=0,
//       release<=1.
//     otherwise deb_cnt++.
//   DEBOUNCE_CYCLES=1: IDLE->HELD and HELD->IDLE take one edge; the
//    PRESSING/RELEASING states are skipped.
//  Latency: a clean edge on btn_n first sampled at edge 1 gives press/release
//   high after edge SYNC_STAGES+DEBOUNCE_CYCLES.
//  Long press: in HELD and RELEASING, hold_cnt increments each cycle and saturates.
//   long<=1 for the single cycle in which hold_cnt becomes LONG_CYCLES-1.
//   No further long pulse until the next accepted press.
//   If release is accepted first, no long pulse is generated.
//  Pulses: press, release and long are registered and high for exactly one cycle.
//   press and release are never high together.
//   long never coincides with press (LONG_CYCLES>=1).
//  Bounce shorter than DEBOUNCE_CYCLES in either direction produces no output change.
//  rst asserted mid-press: outputs clear immediately.
//   After rst drops with the button still held, a fresh press is accepted after
//   SYNC_STAGES+DEBOUNCE_CYCLES edges.
//  Counters never wrap; hold_cnt saturates at 2**CNT_WIDTH-1.
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
//  1 Reset, btn_n=1 for 20 cycles -> all outputs 0 throughout.
//  2 btn_n 1->0 clean at edge 1 -> press=1 only after edge 6, pressed=1 from edge 6;
//    btn_n->1 later -> release=1 one cycle, 6 edges after change.
//  3 btn_n low 3 cycles then high, repeated 5x -> press never asserts, pressed=0.
//  4 Held: press at edge 6, long=1 after edge 15 (9 cycles after the press cycle);
//    keep held 100 cycles -> no second long.
//  5 Held, 2-cycle high glitch in HELD -> no release, pressed stays 1;
//    long timing is unchanged by the glitch.
//  6 rst pulse while pressed=1 and btn_n=0 -> outputs 0 asynchronously;
//    press re-asserts 6 edges after rst deasserts.

Source files
------------

// File: rtl/btn_debounce.sv
// ============================================================================
// Module   : btn_debounce
// Purpose  : Synchronise and debounce an active-low push-button; emit press,
//            release and long-press one-cycle pulses plus a debounced level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int CNT_WIDTH       = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic long
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSING  = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   deb_q, deb_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_WIDTH-1:0]   hold_inc;
  logic                   armed_q, armed_d;
  logic                   pressed_q, pressed_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   long_q, long_d;

  // Chain resets to 1 so a pad already held at reset release reads as a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n};
    end
  end

  assign s        = ~sync_q[SYNC_STAGES-1];
  assign hold_inc = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      deb_q     <= '0;
      hold_q    <= '0;
      armed_q   <= 1'b0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      armed_q   <= armed_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_d     = deb_q;
    hold_d    = hold_q;
    armed_d   = armed_q;
    pressed_d = pressed_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;

    // Hold time keeps running through a release bounce, so a glitch does not delay long.
    if (state_q == HELD || state_q == RELEASING) begin
      hold_d = hold_inc;
      if (armed_q && (hold_inc >= LONG_LAST)) begin
        long_d  = 1'b1;
        armed_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = HELD;
            pressed_d = 1'b1;
            press_d   = 1'b1;
            hold_d    = '0;
            armed_d   = 1'b1;
          end else begin
            state_d = PRESSING;
            deb_d   = CNT_ONE;
          end
        end
      end
      PRESSING: begin
        if (!s) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = HELD;
          deb_d     = '0;
          pressed_d = 1'b1;
          press_d   = 1'b1;
          hold_d    = '0;
          armed_d   = 1'b1;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_d   = IDLE;
            pressed_d = 1'b0;
            rel_d     = 1'b1;
          end else begin
            state_d = RELEASING;
            deb_d   = CNT_ONE;
          end
        end
      end
      RELEASING: begin
        if (s) begin
          state_d = HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d   = IDLE;
          deb_d     = '0;
          pressed_d = 1'b0;
          rel_d     = 1'b1;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end

  assign pressed       = pressed_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign long          = long_q;

endmodule

`default_nettype wire
